// File: rtl/stream_32_output_floating_point32_pkg.sv
// rtl/stream_32_output_floating_point32_pkg.sv - shared sizes and FSM encoding for the FP32 burst streamer
package stream_32_output_floating_point32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_WORDS  = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/stream_buffer_32x32.sv
// rtl/stream_buffer_32x32.sv - 1W/1R register file with write-first read bypass
module stream_buffer_32x32
  import stream_32_output_floating_point32_pkg::*;
#(
  parameter int DW = stream_32_output_floating_point32_pkg::DATA_WIDTH,
  parameter int NW = stream_32_output_floating_point32_pkg::NUM_WORDS,
  parameter int AW = stream_32_output_floating_point32_pkg::ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  // Contents are deliberately not reset.
  logic [DW-1:0] mem_q [NW];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A write landing on the address being read is forwarded the same cycle.
  assign rd_data_o = (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];

endmodule

// File: rtl/stream_32_output_floating_point32.sv
// rtl/stream_32_output_floating_point32.sv - streams a 32-word FP32 buffer as one gap-free burst; STREAM_LAST_EN adds o_last
module stream_32_output_floating_point32
  import stream_32_output_floating_point32_pkg::*;
#(
  parameter int DATA_WIDTH = stream_32_output_floating_point32_pkg::DATA_WIDTH,
  parameter int NUM_WORDS  = stream_32_output_floating_point32_pkg::NUM_WORDS,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_start,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy,
`ifdef STREAM_LAST_EN
  output logic                  o_done,
  output logic                  o_last
`else
  output logic                  o_done
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    buf_wr_en;

  // Buffer is frozen while streaming so a burst always sees one consistent snapshot.
  assign buf_wr_en = i_wr_en && (state_q == IDLE);

  // The word being fetched is the one presented next cycle.
  assign rd_addr = (state_q == STREAM) ? cnt_q + 1'b1 : '0;

  stream_buffer_32x32 #(
    .DW (DATA_WIDTH),
    .NW (NUM_WORDS),
    .AW (ADDR_WIDTH)
  ) u_buffer (
    .clk       (clk),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (i_wr_addr),
    .wr_data_i (i_wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = STREAM;
          cnt_d   = '0;
          data_d  = rd_data;
          valid_d = 1'b1;
        end
      end
      STREAM: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          data_d  = rd_data;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q == STREAM);
  assign o_done  = done_q;

`ifdef STREAM_LAST_EN
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= valid_d && (cnt_d == LAST_ADDR);
    end
  end

  assign o_last = last_q;
`endif

endmodule

// File: tb/tb_stream_32_output_floating_point32.sv
// tb/tb_stream_32_output_floating_point32.sv - scoreboard bench for the FP32 burst streamer
module tb_stream_32_output_floating_point32;

  logic        clk;
  logic        rst_n;
  logic        i_wr_en;
  logic [4:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_start;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;
`ifdef STREAM_LAST_EN
  logic        o_last;
`endif

  stream_32_output_floating_point32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_start   (i_start),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
`ifdef STREAM_LAST_EN
    .o_done    (o_done),
    .o_last    (o_last)
`else
    .o_done    (o_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] tb_mem [32];
  int          total = 0;
  int          bad = 0;
  int          valid_cnt = 0;
  int          done_cnt = 0;
  logic        prev_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: o_done must follow the expected word-31 cycle; every valid word is scored.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      check("done", {31'b0, o_done}, {31'b0, prev_last});
      if (o_done) done_cnt++;
      check("busy", {31'b0, o_busy}, {31'b0, o_valid});
      if (o_valid) begin
        valid_cnt++;
        if (sb_q.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
          prev_last = 1'b0;
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("data", o_data, e.data);
`ifdef STREAM_LAST_EN
          check("last", {31'b0, o_last}, {31'b0, e.last});
`endif
          prev_last = e.last;
        end
      end else begin
        check("idle_data", o_data, 32'd0);
`ifdef STREAM_LAST_EN
        check("idle_last", {31'b0, o_last}, 32'd0);
`endif
        prev_last = 1'b0;
      end
    end
  end

  task automatic push_burst();
    for (int k = 0; k < 32; k++) begin
      exp_t e;
      e.data = tb_mem[k];
      e.last = (k == 31);
      sb_q.push_back(e);
    end
  endtask

  // Drives one cycle from posedge+1; updates the model only when the DUT is idle.
  task automatic write_word(input logic [4:0] a, input logic [31:0] d, input bit idle);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    if (idle) tb_mem[a] = d;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic start_burst(input bit with_wr, input logic [4:0] a, input logic [31:0] d);
    i_start = 1'b1;
    if (with_wr) begin
      i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
      tb_mem[a] = d;
    end
    push_burst();
    @(posedge clk); #1;
    i_start = 1'b0;
    i_wr_en = 1'b0;
    check("start_latency", {31'b0, o_valid}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sb_q.size() == 0 && !o_busy && !o_done) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", {31'b0, (n >= 200)}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  o_data, 32'd0);
    check({tag, "_valid"}, {31'b0, o_valid}, 32'd0);
    check({tag, "_busy"},  {31'b0, o_busy}, 32'd0);
    check({tag, "_done"},  {31'b0, o_done}, 32'd0);
`ifdef STREAM_LAST_EN
    check({tag, "_last"},  {31'b0, o_last}, 32'd0);
`endif
  endtask

  initial begin
    int v0, d0, n;
    rst_n = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_start = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ramp pattern, single burst.
    for (int k = 0; k < 32; k++) write_word(5'(k), 32'h3F800000 + 32'(k), 1'b1);
    v0 = valid_cnt; d0 = done_cnt;
    start_burst(1'b0, '0, '0);
    wait_idle();
    check("b1_words", 32'(valid_cnt - v0), 32'd32);
    check("b1_dones", 32'(done_cnt - d0), 32'd1);

    // Mid-burst write at valid cycle 3 and start at valid cycle 10 are ignored.
    v0 = valid_cnt; d0 = done_cnt;
    start_burst(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #0 write_word(5'd5, 32'hDEADBEEF, 1'b0);
    repeat (6) @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_idle();
    check("b2_words", 32'(valid_cnt - v0), 32'd32);
    check("b2_dones", 32'(done_cnt - d0), 32'd1);

    // Idle write of addr 5 is visible in the next burst.
    write_word(5'd5, 32'hDEADBEEF, 1'b1);
    start_burst(1'b0, '0, '0);
    wait_idle();

    // Write and start in the same cycle: word 0 carries the new value.
    start_burst(1'b1, 5'd0, 32'h40490FDB);
    wait_idle();

    // Asynchronous reset at valid cycle 15 aborts the burst with no o_done.
    start_burst(1'b0, '0, '0);
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    sb_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    start_burst(1'b0, '0, '0);
    wait_idle();

    // Back-to-back: start in the o_done cycle.
    v0 = valid_cnt; d0 = done_cnt;
    start_burst(1'b0, '0, '0);
    n = 0;
    while (!o_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", {31'b0, (n >= 100)}, 32'd0);
    start_burst(1'b0, '0, '0);
    wait_idle();
    check("b2b_words", 32'(valid_cnt - v0), 32'd64);
    check("b2b_dones", 32'(done_cnt - d0), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
